// File: rtl/pipe_hazard_ctrl.sv
// Y86-64 pipeline control: stall/bubble generation, run state and sticky status.
// Define PIPE_HAZARD_CTRL_PERF_EN to implement the saturating performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_cnd,
    input  logic [3:0]       M_icode,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             set_cc_en,
    output logic [1:0]       run_state,
    output logic [2:0]       proc_status,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [2:0] SAOK    = 3'd1;
    localparam logic [2:0] SINS    = 3'd4;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDrain  = 2'd1,
        StHalted = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] status_q, status_d;
    logic [1:0] timer_q, timer_d;

    logic lu, mp, rt;
    logic w_bad, m_bad;

    always_comb begin
        lu = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) && (E_dstM != RNONE) &&
             ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        mp = (E_icode == IJXX) && !e_cnd;
        rt = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
        w_bad = (W_stat != SAOK);
        m_bad = (m_stat != SAOK);
    end

    always_comb begin
        F_stall   = 1'b0;
        D_stall   = 1'b0;
        W_stall   = 1'b0;
        D_bubble  = 1'b0;
        E_bubble  = 1'b0;
        M_bubble  = 1'b0;
        set_cc_en = 1'b0;
        if (rst) begin
            // Flush every stage while reset is held.
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            M_bubble = 1'b1;
        end else begin
            case (state_q)
                StRun: begin
                    F_stall   = (lu || rt) && !mp;
                    D_stall   = lu;
                    D_bubble  = mp || (rt && !lu);
                    E_bubble  = mp || lu;
                    set_cc_en = !m_bad && !w_bad;
                end
                StDrain: begin
                    F_stall  = 1'b1;
                    D_stall  = 1'b1;
                    M_bubble = 1'b1;
                end
                default: begin
                    F_stall  = 1'b1;
                    D_stall  = 1'b1;
                    W_stall  = 1'b1;
                    E_bubble = 1'b1;
                    M_bubble = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        timer_d  = timer_q;
        case (state_q)
            StRun: begin
                timer_d = 2'd0;
                if (w_bad) begin
                    state_d  = StHalted;
                    status_d = W_stat;
                end else if (m_bad) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (w_bad) begin
                    state_d  = StHalted;
                    status_d = W_stat;
                    timer_d  = 2'd0;
                end else if (timer_q == 2'd2) begin
                    // Faulting instruction never reached W: protocol failure.
                    state_d  = StHalted;
                    status_d = SINS;
                    timer_d  = 2'd0;
                end else begin
                    timer_d = timer_q + 2'd1;
                end
            end
            StHalted: ;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StRun;
            status_q <= SAOK;
            timer_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            timer_q  <= timer_d;
        end
    end

    assign run_state   = state_q;
    assign proc_status = status_q;
    assign done        = (state_q == StHalted);

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cycle_q, stall_q, bubble_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q  <= '0;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if ((state_q != StHalted) && (cycle_q != CntMax)) begin
                cycle_q <= cycle_q + 1'b1;
            end
            if ((state_q == StRun) && F_stall && (stall_q != CntMax)) begin
                stall_q <= stall_q + 1'b1;
            end
            if ((state_q == StRun) && (D_bubble || E_bubble) && (bubble_q != CntMax)) begin
                bubble_q <= bubble_q + 1'b1;
            end
        end
    end

    assign cycle_cnt  = cycle_q;
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign cycle_cnt  = '0;
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (small counters to reach saturation).
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    localparam bit Perf = 1'b1;
`else
    localparam bit Perf = 1'b0;
`endif
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst;
    logic [3:0]    D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
    logic          e_cnd;
    logic [2:0]    m_stat, W_stat;
    logic          F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc_en;
    logic [1:0]    run_state;
    logic [2:0]    proc_status;
    logic          done;
    logic [CW-1:0] cycle_cnt, stall_cnt, bubble_cnt;

    int n_checks = 0;
    int n_errors = 0;

    pipe_hazard_ctrl #(.CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .D_icode     (D_icode),
        .d_srcA      (d_srcA),
        .d_srcB      (d_srcB),
        .E_icode     (E_icode),
        .E_dstM      (E_dstM),
        .e_cnd       (e_cnd),
        .M_icode     (M_icode),
        .m_stat      (m_stat),
        .W_stat      (W_stat),
        .F_stall     (F_stall),
        .D_stall     (D_stall),
        .W_stall     (W_stall),
        .D_bubble    (D_bubble),
        .E_bubble    (E_bubble),
        .M_bubble    (M_bubble),
        .set_cc_en   (set_cc_en),
        .run_state   (run_state),
        .proc_status (proc_status),
        .done        (done),
        .cycle_cnt   (cycle_cnt),
        .stall_cnt   (stall_cnt),
        .bubble_cnt  (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Control vector order: {F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc_en}
    task automatic check_ctl(input string tag, input logic [6:0] exp);
        check(tag, {25'd0, F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc_en},
              {25'd0, exp});
    endtask

    // Expected counters are zero when the counters are not built in.
    task automatic check_cnt(input string tag, input int c, input int s, input int b);
        check({tag, "_cycle"}, {28'd0, cycle_cnt}, Perf ? c : 0);
        check({tag, "_stall"}, {28'd0, stall_cnt}, Perf ? s : 0);
        check({tag, "_bubble"}, {28'd0, bubble_cnt}, Perf ? b : 0);
    endtask

    task automatic idle();
        D_icode = 4'h1;
        d_srcA  = 4'hF;
        d_srcB  = 4'hF;
        E_icode = 4'h1;
        E_dstM  = 4'hF;
        e_cnd   = 1'b1;
        M_icode = 4'h1;
        m_stat  = 3'd1;
        W_stat  = 3'd1;
    endtask

    task automatic check_state(input string tag, input int st, input int stat, input bit dn);
        check({tag, "_state"}, {30'd0, run_state}, st);
        check({tag, "_status"}, {29'd0, proc_status}, stat);
        check({tag, "_done"}, {31'd0, done}, {31'd0, dn});
    endtask

    initial begin
        rst = 1'b1;
        idle();
        // t=10: inside reset
        @(negedge clk); #1;
        check_ctl("rst_ctl", 7'b0001110);
        // t=20: release
        @(negedge clk); rst = 1'b0; #1;
        check_state("post_rst", 0, 1, 1'b0);
        check_cnt("post_rst", 0, 0, 0);
        check_ctl("run_idle", 7'b0000001);

        // t=30: load-use
        @(negedge clk); E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; #1;
        check_ctl("loaduse", 7'b1100101);
        // t=40
        @(negedge clk); idle(); #1;
        check_ctl("loaduse_gone", 7'b0000001);
        check_cnt("after_lu", 2, 1, 1);

        // t=50: mispredict with ret in D
        @(negedge clk); E_icode = 4'h7; e_cnd = 1'b0; D_icode = 4'h9; #1;
        check_ctl("mispredict", 7'b0001101);
        // t=60..80: ret walking D, E, M
        @(negedge clk); idle(); D_icode = 4'h9; #1;
        check_cnt("after_mp", 4, 1, 2);
        check_ctl("ret_d", 7'b1001001);
        @(negedge clk); idle(); E_icode = 4'h9; #1;
        check_ctl("ret_e", 7'b1001001);
        @(negedge clk); idle(); M_icode = 4'h9; #1;
        check_ctl("ret_m", 7'b1001001);
        // t=90: ret with concurrent load-use
        @(negedge clk); idle(); M_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h2; d_srcB = 4'h2; #1;
        check_cnt("after_ret", 7, 4, 5);
        check_ctl("ret_lu", 7'b1100101);

        // t=100: address error leaves memory
        @(negedge clk); idle(); m_stat = 3'd3; #1;
        check_cnt("pre_adr", 8, 5, 6);
        check_ctl("m_adr_run", 7'b0000000);
        check("m_adr_state", {30'd0, run_state}, 0);
        // t=110: DRAIN, W now faulting
        @(negedge clk); idle(); W_stat = 3'd3; #1;
        check_state("drain", 1, 1, 1'b0);
        check_ctl("drain_ctl", 7'b1100010);
        // t=120: HALTED
        @(negedge clk); idle(); #1;
        check_state("halt_adr", 2, 3, 1'b1);
        check_ctl("halt_ctl", 7'b1110110);
        check_cnt("halt_a", 10, 5, 6);
        // t=130: frozen
        @(negedge clk); #1;
        check_state("halt_hold", 2, 3, 1'b1);
        check_cnt("halt_b", 10, 5, 6);
        rst = 1'b1; #1;
        check_ctl("rst_in_halt", 7'b0001110);
        // t=140
        @(negedge clk); rst = 1'b0; #1;
        check_state("rst_from_halt", 0, 1, 1'b0);
        check_cnt("rst_from_halt", 0, 0, 0);

        // DRAIN timeout
        m_stat = 3'd4;
        @(negedge clk); idle(); #1;
        check("drain1", {30'd0, run_state}, 1);
        @(negedge clk); #1;
        check("drain2", {30'd0, run_state}, 1);
        @(negedge clk); #1;
        check("drain3", {30'd0, run_state}, 1);
        @(negedge clk); #1;
        check_state("timeout", 2, 4, 1'b1);
        rst = 1'b1; #1;
        check_ctl("rst_bubbles", 7'b0001110);
        @(negedge clk); rst = 1'b0; #1;
        check_state("rst_after_to", 0, 1, 1'b0);
        check_cnt("rst_after_to", 0, 0, 0);

        // Simultaneous m and W faults: W wins
        m_stat = 3'd3; W_stat = 3'd2; #1;
        @(negedge clk); idle(); #1;
        check_state("w_wins", 2, 2, 1'b1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;

        // Saturation: 20 idle RUN cycles
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
        end
        #1;
        check_cnt("saturate", 15, 0, 0);
        check("sat_state", {30'd0, run_state}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
